ddr4_cmd_decoder: RTL

- Front-end stage of the DRAM emulator; sits directly upstream of the bank TimingFSM.
- Samples the raw DDR4 command/address pins on each clk rising edge and decodes the command.
- Tracks CKE power state: active, power-down and self-refresh.
- Produces the registered one-hot command strobes and bank/row/column fields that TimingFSM consumes.

---
 rtl/ddr4_cmd_pkg.sv | 24 ++
 rtl/ddr4_cke_ctrl.sv | 137 +++++++++++++
 rtl/ddr4_cmd_decoder.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ddr4_cmd_pkg.sv
// Shared types and constants for the DDR4 command decoder front-end.
// Holds the power-state encoding, RAS/CAS/WE opcodes and address bit indices.
package ddr4_cmd_pkg;

    typedef enum logic [1:0] {
        PWR_ACTIVE  = 2'd0,
        PWR_PWRDN   = 2'd1,
        PWR_SELFREF = 2'd2,
        PWR_XSWAIT  = 2'd3
    } pwr_state_e;

    // {RAS_n, CAS_n, WE_n} with ACT_n = 1
    localparam logic [2:0] OP_MRS = 3'b000;
    localparam logic [2:0] OP_REF = 3'b001;
    localparam logic [2:0] OP_PRE = 3'b010;
    localparam logic [2:0] OP_WR  = 3'b100;
    localparam logic [2:0] OP_RD  = 3'b101;
    localparam logic [2:0] OP_ZQ  = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    localparam int A10_AP = 10;
    localparam int A12_BC = 12;

endpackage

// File: rtl/ddr4_cke_ctrl.sv
// CKE edge detect, power-state FSM and self-refresh exit (tXS) counter.
// Ports: i_clk, i_reset (async high), i_cke, i_cmd_valid (non-DES/NOP),
//   i_cmd_ref (REF opcode), o_pd/o_pdx/o_srf/o_ckeh/o_ckel/o_illegal
//   (registered pulses), o_cmd_enable (comb), o_pwr_state (registered).
module ddr4_cke_ctrl
    import ddr4_cmd_pkg::*;
#(
    parameter int TXS = 8
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_cke,
    input  logic       i_cmd_valid,
    input  logic       i_cmd_ref,
    output logic       o_pd,
    output logic       o_pdx,
    output logic       o_srf,
    output logic       o_ckeh,
    output logic       o_ckel,
    output logic       o_illegal,
    output logic       o_cmd_enable,
    output logic [1:0] o_pwr_state
);

    localparam int CW = (TXS > 0) ? $clog2(TXS + 1) : 1;
    localparam logic [CW-1:0] TXS_LOAD = (TXS > 0) ? CW'(TXS - 1) : '0;

    logic          r_cke_q;
    pwr_state_e    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_pd;
    logic          r_pdx;
    logic          r_srf;
    logic          r_ckeh;
    logic          r_ckel;
    logic          r_illegal;

    logic          w_fall;
    logic          w_rise;
    pwr_state_e    w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_pd;
    logic          w_pdx;
    logic          w_srf;
    logic          w_illegal;

    assign w_fall = r_cke_q & ~i_cke;
    assign w_rise = ~r_cke_q & i_cke;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pd        = 1'b0;
        w_pdx       = 1'b0;
        w_srf       = 1'b0;
        w_illegal   = 1'b0;
        unique case (r_state)
            PWR_ACTIVE: begin
                if (w_fall) begin
                    // REF with CKE falling becomes self-refresh entry
                    if (i_cmd_ref) begin
                        w_srf       = 1'b1;
                        w_state_nxt = PWR_SELFREF;
                    end else begin
                        w_pd        = 1'b1;
                        w_illegal   = i_cmd_valid;
                        w_state_nxt = PWR_PWRDN;
                    end
                end
            end
            PWR_PWRDN: begin
                w_illegal = i_cmd_valid;
                if (w_rise) begin
                    w_pdx       = 1'b1;
                    w_state_nxt = PWR_ACTIVE;
                end
            end
            PWR_SELFREF: begin
                w_illegal = i_cmd_valid;
                if (w_rise) begin
                    if (TXS == 0) begin
                        w_state_nxt = PWR_ACTIVE;
                    end else begin
                        w_state_nxt = PWR_XSWAIT;
                        w_cnt_nxt   = TXS_LOAD;
                    end
                end
            end
            PWR_XSWAIT: begin
                w_illegal = i_cmd_valid;
                if (w_fall) begin
                    w_pd        = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = PWR_PWRDN;
                end else if (r_cnt == '0) begin
                    w_state_nxt = PWR_ACTIVE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cke_q   <= 1'b0;
            r_state   <= PWR_ACTIVE;
            r_cnt     <= '0;
            r_pd      <= 1'b0;
            r_pdx     <= 1'b0;
            r_srf     <= 1'b0;
            r_ckeh    <= 1'b0;
            r_ckel    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_cke_q   <= i_cke;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pd      <= w_pd;
            r_pdx     <= w_pdx;
            r_srf     <= w_srf;
            r_ckeh    <= w_rise;
            r_ckel    <= w_fall;
            r_illegal <= w_illegal;
        end
    end

    assign o_cmd_enable = (r_state == PWR_ACTIVE) & ~w_fall;
    assign o_pd         = r_pd;
    assign o_pdx        = r_pdx;
    assign o_srf        = r_srf;
    assign o_ckeh       = r_ckeh;
    assign o_ckel       = r_ckel;
    assign o_illegal    = r_illegal;
    assign o_pwr_state  = r_state;

endmodule

// File: rtl/ddr4_cmd_decoder.sv
// DDR4 command/address front-end: decodes pins into registered one-hot strobes
// and bank/row/col fields for the bank timing FSM; CKE power handling in
// ddr4_cke_ctrl. Inputs: clk, reset, cke, cs_n, act_n, shared ras/cas/we pins,
// a[13:0], bg_in, ba_in. Outputs: command strobes, bg, ba, row, col,
// pwr_state, illegal.
module ddr4_cmd_decoder
    import ddr4_cmd_pkg::*;
#(
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int ADDRWIDTH = 17,
    parameter int COLWIDTH  = 10,
    parameter int TXS       = 8,
    parameter int OTF_BC    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cke,
    input  logic                 cs_n,
    input  logic                 act_n,
    input  logic                 ras_n_a16,
    input  logic                 cas_n_a15,
    input  logic                 we_n_a14,
    input  logic [13:0]          a,
    input  logic [BGWIDTH-1:0]   bg_in,
    input  logic [BAWIDTH-1:0]   ba_in,
    output logic                 ACT,
    output logic                 BST,
    output logic                 CFG,
    output logic                 CKEH,
    output logic                 CKEL,
    output logic                 DPD,
    output logic                 DPDX,
    output logic                 MRR,
    output logic                 MRW,
    output logic                 PD,
    output logic                 PDX,
    output logic                 PR,
    output logic                 PRA,
    output logic                 RD,
    output logic                 RDA,
    output logic                 REF,
    output logic                 SRF,
    output logic                 WR,
    output logic                 WRA,
    output logic [BGWIDTH-1:0]   bg,
    output logic [BAWIDTH-1:0]   ba,
    output logic [ADDRWIDTH-1:0] row,
    output logic [COLWIDTH-1:0]  col,
    output logic [1:0]           pwr_state,
    output logic                 illegal
);

    logic [2:0]  w_op;
    logic [16:0] w_row_full;
    logic        w_cmd_valid;
    logic        w_cmd_ref;
    logic        w_cmd_enable;
    logic        w_dec;
    logic        w_act;
    logic        w_cmd;
    logic        w_ap;
    logic        w_wr;
    logic        w_rd;
    logic        w_bst;

    logic                 r_act;
    logic                 r_bst;
    logic                 r_cfg;
    logic                 r_mrw;
    logic                 r_pr;
    logic                 r_pra;
    logic                 r_rd;
    logic                 r_rda;
    logic                 r_ref;
    logic                 r_wr;
    logic                 r_wra;
    logic [BGWIDTH-1:0]   r_bg;
    logic [BAWIDTH-1:0]   r_ba;
    logic [ADDRWIDTH-1:0] r_row;
    logic [COLWIDTH-1:0]  r_col;

    assign w_op       = {ras_n_a16, cas_n_a15, we_n_a14};
    assign w_row_full = {ras_n_a16, cas_n_a15, we_n_a14, a};

    // Anything selected that is not a NOP counts as a real command
    assign w_cmd_valid = ~cs_n & (~act_n | (w_op != OP_NOP));
    assign w_cmd_ref   = ~cs_n & act_n & (w_op == OP_REF);

    assign w_dec = w_cmd_valid & w_cmd_enable;
    assign w_act = w_dec & ~act_n;
    assign w_cmd = w_dec & act_n;
    assign w_ap  = a[A10_AP];
    assign w_wr  = w_cmd & (w_op == OP_WR);
    assign w_rd  = w_cmd & (w_op == OP_RD);
    assign w_bst = (w_wr | w_rd) & (OTF_BC != 0) & ~a[A12_BC];

    ddr4_cke_ctrl #(
        .TXS (TXS)
    ) u_cke_ctrl (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_cke        (cke),
        .i_cmd_valid  (w_cmd_valid),
        .i_cmd_ref    (w_cmd_ref),
        .o_pd         (PD),
        .o_pdx        (PDX),
        .o_srf        (SRF),
        .o_ckeh       (CKEH),
        .o_ckel       (CKEL),
        .o_illegal    (illegal),
        .o_cmd_enable (w_cmd_enable),
        .o_pwr_state  (pwr_state)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_act <= 1'b0;
            r_bst <= 1'b0;
            r_cfg <= 1'b0;
            r_mrw <= 1'b0;
            r_pr  <= 1'b0;
            r_pra <= 1'b0;
            r_rd  <= 1'b0;
            r_rda <= 1'b0;
            r_ref <= 1'b0;
            r_wr  <= 1'b0;
            r_wra <= 1'b0;
            r_bg  <= '0;
            r_ba  <= '0;
            r_row <= '0;
            r_col <= '0;
        end else begin
            r_act <= w_act;
            r_bst <= w_bst;
            r_cfg <= w_cmd & (w_op == OP_ZQ);
            r_mrw <= w_cmd & (w_op == OP_MRS);
            r_ref <= w_cmd & (w_op == OP_REF);
            r_pr  <= w_cmd & (w_op == OP_PRE) & ~w_ap;
            r_pra <= w_cmd & (w_op == OP_PRE) & w_ap;
            r_wr  <= w_wr & ~w_ap;
            r_wra <= w_wr & w_ap;
            r_rd  <= w_rd & ~w_ap;
            r_rda <= w_rd & w_ap;
            if (w_dec) begin
                r_bg <= bg_in;
                r_ba <= ba_in;
            end
            if (w_act) begin
                r_row <= w_row_full[ADDRWIDTH-1:0];
            end
            if (w_wr | w_rd) begin
                r_col <= a[COLWIDTH-1:0];
            end
        end
    end

    assign ACT  = r_act;
    assign BST  = r_bst;
    assign CFG  = r_cfg;
    assign MRW  = r_mrw;
    assign PR   = r_pr;
    assign PRA  = r_pra;
    assign RD   = r_rd;
    assign RDA  = r_rda;
    assign REF  = r_ref;
    assign WR   = r_wr;
    assign WRA  = r_wra;
    assign DPD  = 1'b0;
    assign DPDX = 1'b0;
    assign MRR  = 1'b0;
    assign bg   = r_bg;
    assign ba   = r_ba;
    assign row  = r_row;
    assign col  = r_col;

endmodule
